// File: rtl/scan_pkg.sv
// Shared types and helpers for the multi-digit display scanner.
package scan_pkg;

    localparam int MAX_DIGITS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    // Drive vector with only digit idx active; bits at or above n are 0.
    function automatic logic [MAX_DIGITS-1:0] anode_vec(
        input logic [3:0] idx,
        input logic       active_low,
        input int         n
    );
        logic [MAX_DIGITS-1:0] v;
        v = {MAX_DIGITS{1'b0}};
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) begin
                v[i] = (4'(i) == idx) ? ~active_low : active_low;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/scan_controller_if.sv
// Display-side bundle: enable mask in, digit drives and scan status out.
interface scan_controller_if #(
    parameter int NUM_DIGITS = 8,
    parameter int SEL_W      = $clog2(NUM_DIGITS)
);
    logic [NUM_DIGITS-1:0] digit_en;
    logic [NUM_DIGITS-1:0] anodes;
    logic [SEL_W-1:0]      seg_sel;
    logic                  frame_start;
    logic                  blank;

    modport master (
        input  digit_en,
        output anodes,
        output seg_sel,
        output frame_start,
        output blank
    );

    modport slave (
        output digit_en,
        input  anodes,
        input  seg_sel,
        input  frame_start,
        input  blank
    );
endinterface

// File: rtl/next_digit_finder.sv
// Rotating priority search: first set mask bit strictly after ptr, wrapping modulo NUM_DIGITS.
module next_digit_finder #(
    parameter int NUM_DIGITS = 8,
    parameter int SEL_W      = $clog2(NUM_DIGITS)
) (
    input  logic [NUM_DIGITS-1:0] mask,
    input  logic [SEL_W-1:0]      ptr,
    output logic [SEL_W-1:0]      nxt,
    output logic                  wrap,
    output logic                  any
);

    logic [SEL_W:0]   sum_s;
    logic [SEL_W-1:0] idx_s;

    // Scan distances from farthest to nearest so the nearest set bit wins; distance N lands back on ptr.
    always_comb begin
        nxt   = ptr;
        sum_s = {(SEL_W+1){1'b0}};
        idx_s = {SEL_W{1'b0}};
        for (int k = NUM_DIGITS; k >= 1; k--) begin
            sum_s = {1'b0, ptr} + (SEL_W+1)'(k);
            sum_s = (sum_s >= (SEL_W+1)'(NUM_DIGITS)) ? sum_s - (SEL_W+1)'(NUM_DIGITS) : sum_s;
            idx_s = SEL_W'(sum_s);
            nxt   = mask[idx_s] ? idx_s : nxt;
        end
        any  = |mask;
        wrap = any & (nxt <= ptr);
    end

endmodule

// File: rtl/scan_controller.sv
// Multi-digit display scanner with enable mask, selectable polarity and frame strobe.
// Define SCAN_BLANK_EN to insert an all-off slot after every digit slot.
module scan_controller
    import scan_pkg::*;
#(
    parameter int NUM_DIGITS       = 8,
    parameter int SEL_W            = $clog2(NUM_DIGITS),
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic             clk_480Hz,
    input  logic             reset,
    scan_controller_if.master scan
);

    localparam logic [NUM_DIGITS-1:0] ALL_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

    scan_state_e           state_r,  state_nxt_s;
    logic [SEL_W-1:0]      ptr_r,    ptr_nxt_s;
    logic [NUM_DIGITS-1:0] anodes_r, anodes_nxt_s;
    logic [SEL_W-1:0]      seg_sel_r, seg_sel_nxt_s;
    logic                  frame_start_r, frame_start_nxt_s;
    logic                  blank_r,  blank_nxt_s;

    logic [SEL_W-1:0]      search_ptr_s;
    logic [SEL_W-1:0]      nxt_s;
    logic                  wrap_s;
    logic                  any_s;

    // From IDLE, searching after the last digit yields the lowest enabled digit with wrap set.
    always_comb begin
        search_ptr_s = (state_r == IDLE) ? SEL_W'(NUM_DIGITS - 1) : ptr_r;
    end

    next_digit_finder #(
        .NUM_DIGITS (NUM_DIGITS),
        .SEL_W      (SEL_W)
    ) u_finder (
        .mask (scan.digit_en),
        .ptr  (search_ptr_s),
        .nxt  (nxt_s),
        .wrap (wrap_s),
        .any  (any_s)
    );

    // Next-state logic plus the output values that state will present.
    always_comb begin
        state_nxt_s       = state_r;
        ptr_nxt_s         = ptr_r;
        frame_start_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_nxt_s       = SHOW;
                    ptr_nxt_s         = nxt_s;
                    frame_start_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHOW: begin
                if (!any_s) begin
                    state_nxt_s = IDLE;
                end else begin
`ifdef SCAN_BLANK_EN
                    state_nxt_s = BLANK;
`else
                    state_nxt_s       = SHOW;
                    ptr_nxt_s         = nxt_s;
                    frame_start_nxt_s = wrap_s;
`endif
                end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                if (!any_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s       = SHOW;
                    ptr_nxt_s         = nxt_s;
                    frame_start_nxt_s = wrap_s;
                end
            end
`endif
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        if (state_nxt_s == SHOW) begin
            anodes_nxt_s  = NUM_DIGITS'(anode_vec(4'(ptr_nxt_s), ANODE_ACTIVE_LOW, NUM_DIGITS));
            seg_sel_nxt_s = ptr_nxt_s;
            blank_nxt_s   = 1'b0;
        end else begin
            anodes_nxt_s  = ALL_OFF;
            seg_sel_nxt_s = seg_sel_r;
            blank_nxt_s   = 1'b1;
        end
    end

    // State, pointer and registered outputs.
    always_ff @(posedge clk_480Hz or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            ptr_r         <= {SEL_W{1'b0}};
            anodes_r      <= ALL_OFF;
            seg_sel_r     <= {SEL_W{1'b0}};
            frame_start_r <= 1'b0;
            blank_r       <= 1'b1;
        end else begin
            state_r       <= state_nxt_s;
            ptr_r         <= ptr_nxt_s;
            anodes_r      <= anodes_nxt_s;
            seg_sel_r     <= seg_sel_nxt_s;
            frame_start_r <= frame_start_nxt_s;
            blank_r       <= blank_nxt_s;
        end
    end

    assign scan.anodes      = anodes_r;
    assign scan.seg_sel     = seg_sel_r;
    assign scan.frame_start = frame_start_r;
    assign scan.blank       = blank_r;

endmodule

// File: tb/tb_scan_controller.sv
// Directed bench: an 8-digit active-low scanner and a 4-digit active-high scanner on one clock.
module tb_scan_controller;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    scan_controller_if #(.NUM_DIGITS(8)) bus8 ();
    scan_controller_if #(.NUM_DIGITS(4)) bus4 ();

    scan_controller #(.NUM_DIGITS(8), .ANODE_ACTIVE_LOW(1'b1)) u_dut8 (
        .clk_480Hz (clk),
        .reset     (reset),
        .scan      (bus8.master)
    );

    scan_controller #(.NUM_DIGITS(4), .ANODE_ACTIVE_LOW(1'b0)) u_dut4 (
        .clk_480Hz (clk),
        .reset     (reset),
        .scan      (bus4.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] en8, input logic [3:0] en4);
        reset = 1'b1;
        bus8.digit_en = en8;
        bus4.digit_en = en4;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] got;
        reset = 1'b0;
        bus8.digit_en = 8'hFF;
        bus4.digit_en = 4'hF;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        got = {bus8.anodes, bus8.seg_sel, bus8.frame_start, bus8.blank};
        checks++;
        if (got !== {8'hFF, 3'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset8 got=%h exp=%h", got, {8'hFF, 3'd0, 1'b0, 1'b1});
        end
        checks++;
        if ({bus4.anodes, bus4.seg_sel, bus4.frame_start, bus4.blank} !== {4'h0, 2'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset4 got=%h exp=%h",
                     {bus4.anodes, bus4.seg_sel, bus4.frame_start, bus4.blank}, {4'h0, 2'd0, 1'b0, 1'b1});
        end
    endtask

`ifndef SCAN_BLANK_EN
    task automatic test_full_scan();
        logic [7:0]  an_tbl [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        logic [12:0] got, exp;
        do_reset(8'hFF, 4'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            got = {bus8.anodes, bus8.seg_sel, bus8.frame_start, bus8.blank};
            exp = {an_tbl[i % 8], 3'(i % 8), (i % 8 == 0), 1'b0};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL full_scan slot=%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_sparse();
        logic [7:0]  an_tbl  [3] = '{8'hFB, 8'hDF, 8'h7F};
        logic [2:0]  sel_tbl [3] = '{3'd2, 3'd5, 3'd7};
        logic [12:0] got, exp;
        do_reset(8'b1010_0100, 4'h0);
        for (int i = 0; i < 7; i++) begin
            step();
            got = {bus8.anodes, bus8.seg_sel, bus8.frame_start, bus8.blank};
            exp = {an_tbl[i % 3], sel_tbl[i % 3], (i % 3 == 0), 1'b0};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL sparse slot=%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_idle();
        logic [12:0] got;
        do_reset(8'h00, 4'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            got = {bus8.anodes, bus8.seg_sel, bus8.frame_start, bus8.blank};
            checks++;
            if (got !== {8'hFF, 3'd0, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL idle slot=%0d got=%h exp=%h", i, got, {8'hFF, 3'd0, 1'b0, 1'b1});
            end
        end
        bus8.digit_en = 8'h10;
        for (int i = 0; i < 3; i++) begin
            step();
            got = {bus8.anodes, bus8.seg_sel, bus8.frame_start, bus8.blank};
            checks++;
            if (got !== {8'hEF, 3'd4, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL single_digit slot=%0d got=%h exp=%h", i, got, {8'hEF, 3'd4, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_reset_midscan();
        logic [12:0] got;
        do_reset(8'hFF, 4'h0);
        repeat (6) step();
        got = {bus8.anodes, bus8.seg_sel, bus8.frame_start, bus8.blank};
        checks++;
        if (got !== {8'hDF, 3'd5, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL pre_reset got=%h exp=%h", got, {8'hDF, 3'd5, 1'b0, 1'b0});
        end
        #2;
        reset = 1'b1;
        #1;
        got = {bus8.anodes, bus8.seg_sel, bus8.frame_start, bus8.blank};
        checks++;
        if (got !== {8'hFF, 3'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", got, {8'hFF, 3'd0, 1'b0, 1'b1});
        end
        bus8.digit_en = 8'b0011_0000;
        @(negedge clk);
        reset = 1'b0;
        step();
        got = {bus8.anodes, bus8.seg_sel, bus8.frame_start, bus8.blank};
        checks++;
        if (got !== {8'hEF, 3'd4, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL restart got=%h exp=%h", got, {8'hEF, 3'd4, 1'b1, 1'b0});
        end
    endtask

    task automatic test_disable_mid();
        logic [12:0] got;
        do_reset(8'hFF, 4'h0);
        repeat (4) step();
        bus8.digit_en = 8'hF7;
        #2;
        got = {bus8.anodes, bus8.seg_sel, bus8.frame_start, bus8.blank};
        checks++;
        if (got !== {8'hF7, 3'd3, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL disable_hold got=%h exp=%h", got, {8'hF7, 3'd3, 1'b0, 1'b0});
        end
        step();
        got = {bus8.anodes, bus8.seg_sel, bus8.frame_start, bus8.blank};
        checks++;
        if (got !== {8'hEF, 3'd4, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL disable_adv got=%h exp=%h", got, {8'hEF, 3'd4, 1'b0, 1'b0});
        end
        bus8.digit_en = 8'h08;
        step();
        got = {bus8.anodes, bus8.seg_sel, bus8.frame_start, bus8.blank};
        checks++;
        if (got !== {8'hF7, 3'd3, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL wrap_back got=%h exp=%h", got, {8'hF7, 3'd3, 1'b1, 1'b0});
        end
    endtask

    task automatic test_active_high();
        logic [3:0] an_tbl [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
        logic [7:0] got, exp;
        do_reset(8'h00, 4'hF);
        for (int i = 0; i < 5; i++) begin
            step();
            got = {bus4.anodes, bus4.seg_sel, bus4.frame_start, bus4.blank};
            exp = {an_tbl[i % 4], 2'(i % 4), (i % 4 == 0), 1'b0};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL active_high slot=%0d got=%h exp=%h", i, got, exp);
            end
        end
        do_reset(8'h00, 4'h8);
        for (int i = 0; i < 3; i++) begin
            step();
            got = {bus4.anodes, bus4.seg_sel, bus4.frame_start, bus4.blank};
            checks++;
            if (got !== {4'h8, 2'd3, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL single_ah slot=%0d got=%h exp=%h", i, got, {4'h8, 2'd3, 1'b1, 1'b0});
            end
        end
    endtask
`else
    task automatic test_blank();
        logic [7:0]  an_tbl [4] = '{8'hFE, 8'hFF, 8'hFD, 8'hFF};
        logic [2:0]  sel_tbl[4] = '{3'd0, 3'd0, 3'd1, 3'd1};
        logic [12:0] got, exp;
        do_reset(8'h03, 4'h0);
        for (int i = 0; i < 9; i++) begin
            step();
            got = {bus8.anodes, bus8.seg_sel, bus8.frame_start, bus8.blank};
            exp = {an_tbl[i % 4], sel_tbl[i % 4], (i % 4 == 0), (i % 2 == 1)};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL blank slot=%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus8.digit_en = 8'h00;
        bus4.digit_en = 4'h0;
        test_reset();
`ifndef SCAN_BLANK_EN
        test_full_scan();
        test_sparse();
        test_idle();
        test_reset_midscan();
        test_disable_mid();
        test_active_high();
`else
        test_blank();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_controller.md
# scan_controller

Parametrised multi-digit scan controller for the memory display. It time-multiplexes NUM_DIGITS common-anode (or common-cathode) digits at the 480 Hz scan clock, driving one-hot digit enables and a digit index (seg_sel) to the segment-data mux. Compared with the fixed 8-digit scanner, it adds:
- a per-digit enable mask, so disabled digits are skipped without dead slots;
- configurable enable polarity;
- a frame-start strobe;
- an optional anti-ghosting blank slot.

## Interface
Parameters:
- NUM_DIGITS, 8, number of digits scanned; legal range 2..16.
- SEL_W, $clog2(NUM_DIGITS), width of seg_sel. Derived; do not override.
- ANODE_ACTIVE_LOW, 1, 1 = selected digit driven 0, others 1; 0 = inverted.

Ports:
- clk_480Hz  input  1  scan clock. One digit slot per rising edge.
- reset  input  1  asynchronous, active-high.
- digit_en  input  NUM_DIGITS  per-digit enable mask. Bit i = digit i participates in the scan.
- anodes  output  NUM_DIGITS  digit drives. At most one active per cycle; polarity per ANODE_ACTIVE_LOW.
- seg_sel  output  SEL_W  index of the digit currently driven.
- frame_start  output  1  one-cycle pulse on the first slot of each scan frame.
- blank  output  1  high when no digit is driven (IDLE or BLANK state).

## Operation
- All outputs are registered.
- State machine: IDLE, SHOW, BLANK (BLANK exists only with SCAN_BLANK_EN).
- Registers: state, ptr[SEL_W-1:0].
- The next-digit search is a rotating priority search of digit_en, starting at ptr+1 mod NUM_DIGITS and returning the first set bit (nxt) and a wrap flag. The wrap flag is set when nxt <= ptr, or when entering SHOW from IDLE.

Transitions:
- IDLE: if digit_en == 0, stay. Otherwise go to SHOW with ptr = lowest set bit of digit_en, and assert frame_start.
- SHOW: if digit_en == 0, go to IDLE. Otherwise:
  - without SCAN_BLANK_EN: ptr <= nxt, stay in SHOW, and set frame_start = wrap;
  - with SCAN_BLANK_EN: go to BLANK, holding ptr.
- BLANK: if digit_en == 0, go to IDLE. Otherwise go to SHOW with ptr <= nxt and frame_start = wrap.

Outputs:
- In SHOW: anodes has only bit ptr active; seg_sel = ptr; blank = 0.
- In IDLE or BLANK: all anodes inactive; seg_sel holds its last value (0 after reset); blank = 1.

Boundary conditions:
- Single enabled digit: SHOW persists on that digit, and frame_start pulses on every SHOW entry. Without blank, that means every cycle.
- Current digit disabled mid-slot: that digit's display continues until the next edge, then the scan advances normally. No glitch within the cycle.
- ptr == NUM_DIGITS-1 wraps to the lowest set bit, and wrap is set.
- digit_en is sampled only on clk_480Hz edges. It is assumed to be synchronous to clk_480Hz or quasi-static; no internal synchronizer.

## Timing
- Reset (asynchronous assert) gives: state = IDLE, ptr = 0, anodes = all inactive (all 1s when ANODE_ACTIVE_LOW = 1), seg_sel = 0, frame_start = 0, blank = 1.
- Reset deassert mid-scan restarts from IDLE.
- First SHOW occurs on the first rising edge after reset deasserts, provided digit_en != 0 at that edge.
- Latency from a digit_en change to its effect on the outputs: 1 edge.
- Frame length:
  - without blank: popcount(digit_en) cycles;
  - with blank: 2 × popcount(digit_en) cycles.
- All output changes are aligned to rising edges of clk_480Hz. No combinational path from any input to any output.

## Configuration
- SCAN_BLANK_EN defined: a one-cycle BLANK slot (all anodes off) is inserted after every SHOW slot. This suppresses ghosting from segment-data settling, at the cost of a 50 % duty cycle.
- SCAN_BLANK_EN undefined: the BLANK state and its logic are removed, and SHOW advances directly every cycle.

## Structure
- Shared package scan_pkg:
  - state enum (IDLE, SHOW, BLANK);
  - function anode_vec(idx, active_low, n) returning the one-hot/inverted drive vector;
  - constant MAX_DIGITS = 16.
- Sub-module next_digit_finder: combinational rotating priority search. Parameter NUM_DIGITS. Inputs: mask and ptr. Outputs: nxt, wrap, any. Reused by the FSM for the IDLE entry point (ptr forced to NUM_DIGITS-1).

## Test plan
- Reset then NUM_DIGITS = 8, digit_en = 8'hFF, no blank: anodes = FE, FD, FB, … 7F, FE. seg_sel = 0..7, 0. frame_start high at seg_sel = 0 only.
- digit_en = 8'b1010_0100: seg_sel sequence 2, 5, 7, 2, … with anodes FB, DF, 7F. frame_start on each 2. Frame = 3 cycles.
- digit_en = 8'h00 after reset: stays IDLE, anodes = FF, blank = 1, frame_start never asserts. Then set digit_en = 8'h10: next edge gives seg_sel = 4, anodes = EF, frame_start = 1.
- SCAN_BLANK_EN, digit_en = 8'h03: SHOW 0 (FE), BLANK (FF), SHOW 1 (FD), BLANK (FF), repeat. blank toggles every cycle.
- Assert reset while seg_sel = 5: anodes immediately FF, seg_sel = 0, blank = 1 without waiting for a clock edge. After release, scan restarts at the lowest enabled digit with frame_start.
- ANODE_ACTIVE_LOW = 0, NUM_DIGITS = 4, digit_en = 4'hF: anodes = 1, 2, 4, 8. SEL_W = 2. Single-digit mask 4'h8 gives anodes = 8 every cycle, with frame_start held high every cycle.
